// File: rtl/ltc2308_sampler.sv
// ltc2308_sampler: periodically runs one LTC2308 conversion frame over the
// 4-wire SPI ADC bus (CONVST, SCK, SDI, SDO) and holds the latest 12-bit
// result on a stable output, pulsing adc_valid for one clk when it updates.
module ltc2308_sampler #(
    parameter int CLK_DIV       = 2,     // clk cycles per SCK half-period (1..255)
    parameter int CONV_CYCLES   = 80,    // clk cycles CONVST is held high
    parameter int SAMPLE_PERIOD = 2500   // clk cycles between frame starts
) (
    input  logic        clk,
    input  logic        reset,        // synchronous, active-low
    input  logic [2:0]  channel,
    output logic        adc_convst,
    output logic        adc_sck,
    output logic        adc_sdi,
    input  logic        adc_sdo,
    output logic [11:0] adc_value,
    output logic        adc_valid,
    output logic        busy
);

    // Counter widths; a parameter of 1 still needs a 1-bit counter.
    localparam int DIV_W  = (CLK_DIV > 1)       ? $clog2(CLK_DIV)       : 1;
    localparam int CONV_W = (CONV_CYCLES > 1)   ? $clog2(CONV_CYCLES)   : 1;
    localparam int PER_W  = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [CONV_W-1:0] CONV_LAST = CONV_W'(CONV_CYCLES - 1);
    localparam logic [PER_W-1:0]  PER_LAST  = PER_W'(SAMPLE_PERIOD - 1);
    localparam logic [3:0]        BIT_LAST  = 4'd11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONV,
        ST_SHIFT,
        ST_DONE
    } state_t;

    state_t              state_q,    state_d;
    logic [PER_W-1:0]    per_cnt_q,  per_cnt_d;
    logic [CONV_W-1:0]   conv_cnt_q, conv_cnt_d;
    logic [DIV_W-1:0]    div_cnt_q,  div_cnt_d;
    logic [3:0]          bit_cnt_q,  bit_cnt_d;
    logic [5:0]          cfg_q,      cfg_d;      // config word, MSB shifted out first
    logic [11:0]         res_q,      res_d;      // result being assembled, MSB first
    logic                convst_q,   convst_d;
    logic                sck_q,      sck_d;
    logic                sdi_q,      sdi_d;
    logic [11:0]         value_q,    value_d;
    logic                valid_q,    valid_d;
    logic                busy_q,     busy_d;
    logic                frame_start;

    // State register; reset aborts any frame in progress without writing a result.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            per_cnt_q  <= '0;
            conv_cnt_q <= '0;
            div_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            cfg_q      <= '0;
            res_q      <= '0;
            convst_q   <= 1'b0;
            sck_q      <= 1'b0;
            sdi_q      <= 1'b0;
            value_q    <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            per_cnt_q  <= per_cnt_d;
            conv_cnt_q <= conv_cnt_d;
            div_cnt_q  <= div_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            cfg_q      <= cfg_d;
            res_q      <= res_d;
            convst_q   <= convst_d;
            sck_q      <= sck_d;
            sdi_q      <= sdi_d;
            value_q    <= value_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
        end
    end

    // Next-state logic: period counter, frame sequencing and the SPI bit engine.
    always_comb begin
        state_d    = state_q;
        conv_cnt_d = conv_cnt_q;
        div_cnt_d  = div_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        cfg_d      = cfg_q;
        res_d      = res_q;
        convst_d   = convst_q;
        sck_d      = sck_q;
        sdi_d      = sdi_q;
        value_d    = value_q;
        valid_d    = 1'b0;

        // Free-running period counter; a start that lands mid-frame is simply lost.
        per_cnt_d   = (per_cnt_q == PER_LAST) ? '0 : per_cnt_q + PER_W'(1);
        frame_start = (state_q == ST_IDLE) && (per_cnt_q == '0);

        unique case (state_q)
            ST_IDLE: begin
                if (frame_start) begin
                    // S/D, O/S, S1, S0, UNI, SLP; channel bits are reordered for the mux.
                    cfg_d      = {1'b1, channel[0], channel[2], channel[1], 1'b1, 1'b0};
                    convst_d   = 1'b1;
                    conv_cnt_d = '0;
                    state_d    = ST_CONV;
                end
            end

            ST_CONV: begin
                if (conv_cnt_q == CONV_LAST) begin
                    // Conversion finished: drop CONVST and present the first config bit.
                    convst_d  = 1'b0;
                    sdi_d     = cfg_q[5];
                    cfg_d     = {cfg_q[4:0], 1'b0};
                    div_cnt_d = '0;
                    bit_cnt_d = '0;
                    sck_d     = 1'b0;
                    state_d   = ST_SHIFT;
                end else begin
                    conv_cnt_d = conv_cnt_q + CONV_W'(1);
                end
            end

            ST_SHIFT: begin
                if (div_cnt_q == DIV_LAST) begin
                    div_cnt_d = '0;
                    if (!sck_q) begin
                        // Rising SCK: the ADC has held this SDO bit since the last fall.
                        sck_d = 1'b1;
                        res_d = {res_q[10:0], adc_sdo};
                    end else begin
                        // Falling SCK: advance SDI; zeros follow once cfg is exhausted.
                        sck_d = 1'b0;
                        sdi_d = cfg_q[5];
                        cfg_d = {cfg_q[4:0], 1'b0};
                        if (bit_cnt_q == BIT_LAST) begin
                            state_d = ST_DONE;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end
                end else begin
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                end
            end

            ST_DONE: begin
                value_d = res_q;
                valid_d = 1'b1;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // busy covers the whole frame and stays up through the adc_valid cycle.
        busy_d = (state_d != ST_IDLE) || (state_q == ST_DONE);
    end

    assign adc_convst = convst_q;
    assign adc_sck    = sck_q;
    assign adc_sdi    = sdi_q;
    assign adc_value  = value_q;
    assign adc_valid  = valid_q;
    assign busy       = busy_q;

endmodule
